// File: rtl/wb_ctrl_pkg.sv
// wb_ctrl_pkg: shared definitions for the white balance control sequencer.
//   - mode codes driven on wb_ctrl_if.mode
//   - channel codes driven on wb_ctrl_if.man_sel
//   - command opcodes (cmd_op_t) and sequencer states (seq_state_t)
//   - is_bad_sel(): WRITE/READ commands addressing the non-existent channel 3
package wb_ctrl_pkg;

    localparam logic [1:0] AUTO_GW     = 2'd0;
    localparam logic [1:0] AUTO_R      = 2'd1;
    localparam logic [1:0] MANUAL      = 2'd2;
    localparam logic [1:0] CALIBRATION = 2'd3;

    localparam logic [1:0] RED   = 2'd0;
    localparam logic [1:0] GREEN = 2'd1;
    localparam logic [1:0] BLUE  = 2'd2;

    typedef enum logic [1:0] {
        CMD_SET_MODE   = 2'd0,
        CMD_WRITE_COEF = 2'd1,
        CMD_READ_COEF  = 2'd2,
        CMD_CALIBRATE  = 2'd3
    } cmd_op_t;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_SOF  = 3'd1,
        ST_APPLY     = 3'd2,
        ST_READ_WAIT = 3'd3,
        ST_CAL_CNT   = 3'd4,
        ST_CAL_STB   = 3'd5
    } seq_state_t;

    function automatic logic is_bad_sel(input cmd_op_t op, input logic [1:0] sel);
        return ((op == CMD_WRITE_COEF) || (op == CMD_READ_COEF)) && (sel == 2'd3);
    endfunction

endpackage

// File: rtl/wb_ctrl_if.sv
// wb_ctrl_if: control bus between the host-side sequencer and the white
// balance corrector.
//   mode[1:0]    operating mode (AUTO_GW / AUTO_R / MANUAL / CALIBRATION)
//   man_sel[1:0] channel addressed for manual write and coefficient readback
//   man_coef     manual coefficient value, qualified by man_lock
//   man_lock     one-cycle strobe: corrector latches man_coef into man_sel
//   cal_stb      one-cycle strobe: corrector freezes its calibration result
//   cur_coef     corrector's current coefficient for man_sel (READ_LAT behind)
// master = sequencer, slave = corrector.
interface wb_ctrl_if #(
    parameter int COEF_WIDTH = 20
);
    logic [1:0]            mode;
    logic [1:0]            man_sel;
    logic [COEF_WIDTH-1:0] man_coef;
    logic                  man_lock;
    logic                  cal_stb;
    logic [COEF_WIDTH-1:0] cur_coef;

    modport master (
        output mode, man_sel, man_coef, man_lock, cal_stb,
        input  cur_coef
    );

    modport slave (
        input  mode, man_sel, man_coef, man_lock, cal_stb,
        output cur_coef
    );
endinterface

// File: rtl/wb_frame_timer.sv
// wb_frame_timer: frame counter for calibration plus optional SOF watchdog.
//   clk_i, rst_i   clock, asynchronous active-high reset
//   sof_i          start-of-frame pulse
//   clear_i        restart both counters (sequencer entering a wait state)
//   count_en_i     count SOFs (sequencer in CAL_CNT)
//   watch_en_i     watchdog armed (sequencer in WAIT_SOF or CAL_CNT)
//   frames_done_o  combinational: this SOF is the CAL_FRAMES-th counted one
//   timeout_o      combinational: TIMEOUT_CYCLES elapsed without SOF
// Macro WB_SEQ_TIMEOUT_EN builds the watchdog; otherwise timeout_o is 0.
module wb_frame_timer #(
    parameter int CAL_FRAMES     = 2,
    parameter int TIMEOUT_CYCLES = 2**24
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic sof_i,
    input  logic clear_i,
    input  logic count_en_i,
    input  logic watch_en_i,
    output logic frames_done_o,
    output logic timeout_o
);
    localparam int FW = (CAL_FRAMES > 1) ? $clog2(CAL_FRAMES) : 1;

    logic [FW-1:0] frame_cnt_q;
    logic          last_frame;

    // Modulo-CAL_FRAMES counter, 0-based: wraps on the final counted SOF.
    assign last_frame    = (frame_cnt_q == FW'(CAL_FRAMES - 1));
    assign frames_done_o = count_en_i && sof_i && last_frame;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            frame_cnt_q <= '0;
        end else if (clear_i) begin
            frame_cnt_q <= '0;
        end else if (count_en_i && sof_i) begin
            frame_cnt_q <= last_frame ? '0 : frame_cnt_q + 1'b1;
        end
    end

`ifdef WB_SEQ_TIMEOUT_EN
    localparam int WW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [WW-1:0] wd_cnt_q;
    logic          wd_limit;

    assign wd_limit = (wd_cnt_q == WW'(TIMEOUT_CYCLES - 1));
    // A SOF in the same cycle as the limit counts as progress, not a timeout.
    assign timeout_o = watch_en_i && !sof_i && wd_limit;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wd_cnt_q <= '0;
        end else if (clear_i || sof_i) begin
            wd_cnt_q <= '0;
        end else if (watch_en_i && !wd_limit) begin
            wd_cnt_q <= wd_cnt_q + 1'b1;
        end
    end
`else
    // Watchdog compiled out; the comparison only keeps the port and
    // parameter referenced and is constant false.
    assign timeout_o = watch_en_i && (TIMEOUT_CYCLES < 0);
`endif

endmodule

// File: rtl/wb_ctrl_sequencer.sv
// wb_ctrl_sequencer: host-side controller driving the white balance
// corrector's control bus. Accepts one command at a time, applies mode and
// coefficient changes on frame boundaries and sequences calibration.
//   clk_i, rst_i       clock, asynchronous active-high reset
//   sof_i              start-of-frame pulse (one cycle per frame)
//   cmd_valid_i/cmd_ready_o/cmd_op_i/cmd_sel_i/cmd_data_i  command channel
//   rsp_valid_o/rsp_err_o/rsp_data_o                        completion
//   state_o            current sequencer state (debug)
//   wb_ctrl_o          wb_ctrl_if master port
// Macro WB_SEQ_TIMEOUT_EN enables the SOF watchdog (TIMEOUT_CYCLES).
//
// Command handshake: a command transfers on a rising clock edge where
// cmd_valid_i && cmd_ready_o; cmd_ready_o is high only in IDLE and does not
// depend on cmd_valid_i. Fields are registered at transfer, so the host may
// change them afterwards. Completion is a single-cycle rsp_valid_o pulse with
// no back-pressure; rsp_err_o qualifies it.
module wb_ctrl_sequencer
    import wb_ctrl_pkg::*;
#(
    parameter int COEF_WIDTH     = 20,
    parameter int CAL_FRAMES     = 2,
    parameter int READ_LAT       = 2,
    parameter int TIMEOUT_CYCLES = 2**24
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  sof_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic [1:0]            cmd_op_i,
    input  logic [1:0]            cmd_sel_i,
    input  logic [COEF_WIDTH-1:0] cmd_data_i,
    output logic                  rsp_valid_o,
    output logic                  rsp_err_o,
    output logic [COEF_WIDTH-1:0] rsp_data_o,
    output seq_state_t            state_o,
    wb_ctrl_if.master             wb_ctrl_o
);
    localparam int RW = $clog2(READ_LAT + 1);

    seq_state_t            state_q, state_d;
    cmd_op_t               op_q;
    logic [1:0]            sel_q;
    logic [COEF_WIDTH-1:0] data_q;
    logic [1:0]            mode_q;
    logic [1:0]            man_sel_q;
    logic [COEF_WIDTH-1:0] man_coef_q;
    logic [RW-1:0]         rd_cnt_q;
    logic                  rsp_valid_q, rsp_err_q;
    logic [COEF_WIDTH-1:0] rsp_data_q;
`ifdef WB_SEQ_TIMEOUT_EN
    logic [1:0]            mode_prev_q;
`endif

    logic accept, bad_sel, rd_done;
    logic timer_clear, frames_done, timeout;

    assign cmd_ready_o = (state_q == ST_IDLE);
    assign accept      = cmd_valid_i && cmd_ready_o;
    assign bad_sel     = is_bad_sel(cmd_op_t'(cmd_op_i), cmd_sel_i);
    assign rd_done     = (rd_cnt_q == RW'(READ_LAT));

    wb_frame_timer #(
        .CAL_FRAMES     (CAL_FRAMES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_frame_timer (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .sof_i         (sof_i),
        .clear_i       (timer_clear),
        .count_en_i    (state_q == ST_CAL_CNT),
        .watch_en_i    ((state_q == ST_WAIT_SOF) || (state_q == ST_CAL_CNT)),
        .frames_done_o (frames_done),
        .timeout_o     (timeout)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state. In IDLE an acceptance cycle never looks at sof_i, which is
    // what makes a SOF coinciding with acceptance wait for the next frame.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept && !bad_sel) begin
                    state_d = (cmd_op_t'(cmd_op_i) == CMD_READ_COEF) ? ST_READ_WAIT : ST_WAIT_SOF;
                end
            end
            ST_WAIT_SOF: begin
                if (sof_i) begin
                    state_d = (op_q == CMD_CALIBRATE) ? ST_CAL_CNT : ST_APPLY;
                end else if (timeout) begin
                    state_d = ST_IDLE;
                end
            end
            ST_APPLY:     state_d = ST_IDLE;
            ST_READ_WAIT: if (rd_done) state_d = ST_IDLE;
            ST_CAL_CNT: begin
                if (frames_done) begin
                    state_d = ST_CAL_STB;
                end else if (timeout) begin
                    state_d = ST_IDLE;
                end
            end
            ST_CAL_STB:   state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
        timer_clear = (state_d != state_q) &&
                      ((state_d == ST_WAIT_SOF) || (state_d == ST_CAL_CNT));
    end

    // Datapath registers, keyed on the current state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            op_q        <= CMD_SET_MODE;
            sel_q       <= '0;
            data_q      <= '0;
            mode_q      <= AUTO_GW;
            man_sel_q   <= RED;
            man_coef_q  <= '0;
            rd_cnt_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= '0;
`ifdef WB_SEQ_TIMEOUT_EN
            mode_prev_q <= AUTO_GW;
`endif
        end else begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    rd_cnt_q <= '0;
                    if (accept) begin
                        op_q   <= cmd_op_t'(cmd_op_i);
                        sel_q  <= cmd_sel_i;
                        data_q <= cmd_data_i;
`ifdef WB_SEQ_TIMEOUT_EN
                        mode_prev_q <= mode_q;
`endif
                        if (bad_sel) begin
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                        end else if (cmd_op_t'(cmd_op_i) == CMD_READ_COEF) begin
                            // Readback address goes out right away; the
                            // corrector needs READ_LAT cycles to follow.
                            man_sel_q <= cmd_sel_i;
                        end
                    end
                end
                ST_WAIT_SOF: begin
                    if (sof_i) begin
                        case (op_q)
                            CMD_SET_MODE:   mode_q <= sel_q;
                            CMD_WRITE_COEF: begin
                                man_sel_q  <= sel_q;
                                man_coef_q <= data_q;
                            end
                            CMD_CALIBRATE:  mode_q <= CALIBRATION;
                            default:        ;
                        endcase
                    end else if (timeout) begin
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b1;
                    end
                end
                ST_APPLY: rsp_valid_q <= 1'b1;
                ST_READ_WAIT: begin
                    rd_cnt_q <= rd_cnt_q + 1'b1;
                    if (rd_done) begin
                        rsp_data_q  <= wb_ctrl_o.cur_coef;
                        rsp_valid_q <= 1'b1;
                    end
                end
                ST_CAL_CNT: begin
`ifdef WB_SEQ_TIMEOUT_EN
                    if (!frames_done && timeout) begin
                        // Abandoned calibration must not leave coefs frozen.
                        mode_q      <= mode_prev_q;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b1;
                    end
`endif
                end
                // Mode stays CALIBRATION after the strobe: coefs remain frozen.
                ST_CAL_STB: rsp_valid_q <= 1'b1;
                default: ;
            endcase
        end
    end

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_err_o   = rsp_err_q;
    assign rsp_data_o  = rsp_data_q;
    assign state_o     = state_q;

    // Strobes decode from exclusive states, so they can never overlap.
    assign wb_ctrl_o.mode     = mode_q;
    assign wb_ctrl_o.man_sel  = man_sel_q;
    assign wb_ctrl_o.man_coef = man_coef_q;
    assign wb_ctrl_o.man_lock = (state_q == ST_APPLY) && (op_q == CMD_WRITE_COEF);
    assign wb_ctrl_o.cal_stb  = (state_q == ST_CAL_STB);

endmodule

// File: tb/tb_wb_ctrl_sequencer.sv
// tb_wb_ctrl_sequencer: directed bench for wb_ctrl_sequencer with a simple
// corrector model (per-channel coefficient table behind a READ_LAT-deep
// man_sel pipeline). Watchdog steps are built when WB_SEQ_TIMEOUT_EN is set.
module tb_wb_ctrl_sequencer;
    import wb_ctrl_pkg::*;

    localparam int CW = 20;

    logic          clk_i, rst_i, sof_i;
    logic          cmd_valid_i, cmd_ready_o;
    logic [1:0]    cmd_op_i, cmd_sel_i;
    logic [CW-1:0] cmd_data_i;
    logic          rsp_valid_o, rsp_err_o;
    logic [CW-1:0] rsp_data_o;
    seq_state_t    state_o;

    wb_ctrl_if #(.COEF_WIDTH(CW)) bus ();

    wb_ctrl_sequencer #(
        .COEF_WIDTH     (CW),
        .CAL_FRAMES     (2),
        .READ_LAT       (2),
        .TIMEOUT_CYCLES (64)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .sof_i       (sof_i),
        .cmd_valid_i (cmd_valid_i),
        .cmd_ready_o (cmd_ready_o),
        .cmd_op_i    (cmd_op_i),
        .cmd_sel_i   (cmd_sel_i),
        .cmd_data_i  (cmd_data_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_err_o   (rsp_err_o),
        .rsp_data_o  (rsp_data_o),
        .state_o     (state_o),
        .wb_ctrl_o   (bus)
    );

    // Clock / reset
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Corrector model: cur_coef follows man_sel two cycles late.
    logic [1:0] sel_d1, sel_d2;
    always @(posedge clk_i) begin
        sel_d1 <= bus.man_sel;
        sel_d2 <= sel_d1;
    end
    always_comb begin
        case (sel_d2)
            2'd0:    bus.cur_coef = 20'h12345;
            2'd1:    bus.cur_coef = 20'h0ABCD;
            2'd2:    bus.cur_coef = 20'h0059F;
            default: bus.cur_coef = 20'hFFFFF;
        endcase
    end

    // Strobe monitors, sampled mid-cycle.
    int            lock_cnt, stb_cnt, overlap_cnt;
    logic [1:0]    lock_sel;
    logic [CW-1:0] lock_coef;
    always @(negedge clk_i) begin
        if (rst_i) begin
            lock_cnt <= 0; stb_cnt <= 0; overlap_cnt <= 0;
            lock_sel <= '0; lock_coef <= '0;
        end else begin
            if (bus.man_lock) begin
                lock_cnt  <= lock_cnt + 1;
                lock_sel  <= bus.man_sel;
                lock_coef <= bus.man_coef;
            end
            if (bus.cal_stb) stb_cnt <= stb_cnt + 1;
            if (bus.man_lock && bus.cal_stb) overlap_cnt <= overlap_cnt + 1;
        end
    end

    // Scoreboard counters
    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Driver tasks
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic send_cmd(input logic [1:0] op, input logic [1:0] sel, input logic [CW-1:0] data);
        cmd_op_i = op; cmd_sel_i = sel; cmd_data_i = data; cmd_valid_i = 1'b1;
        chk("ready_at_accept", 32'(cmd_ready_o), 32'd1);
        step();
        cmd_valid_i = 1'b0;
    endtask

    task automatic sof_after(input int gap);
        repeat (gap - 1) step();
        sof_i = 1'b1;
        step();
        sof_i = 1'b0;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        #1;
        step();
        rst_i = 1'b0;
    endtask

    int k;

    initial begin
        rst_i = 1'b1; sof_i = 1'b0; cmd_valid_i = 1'b0;
        cmd_op_i = '0; cmd_sel_i = '0; cmd_data_i = '0;
        repeat (3) step();
        rst_i = 1'b0;
        step();

        // Reset state
        chk("rst_mode",      32'(bus.mode),     32'd0);
        chk("rst_man_sel",   32'(bus.man_sel),  32'd0);
        chk("rst_man_coef",  32'(bus.man_coef), 32'd0);
        chk("rst_man_lock",  32'(bus.man_lock), 32'd0);
        chk("rst_cal_stb",   32'(bus.cal_stb),  32'd0);
        chk("rst_ready",     32'(cmd_ready_o),  32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid_o),  32'd0);
        chk("rst_rsp_err",   32'(rsp_err_o),    32'd0);
        chk("rst_rsp_data",  32'(rsp_data_o),   32'd0);
        chk("rst_state",     32'(state_o),      32'(ST_IDLE));

        // SET_MODE sel=2, SOF 10 cycles later; a second command is offered
        // while busy and must be refused.
        send_cmd(2'd0, 2'd2, '0);
        chk("set_busy_ready", 32'(cmd_ready_o), 32'd0);
        chk("set_wait_state", 32'(state_o), 32'(ST_WAIT_SOF));
        cmd_op_i = 2'd0; cmd_sel_i = 2'd1; cmd_valid_i = 1'b1;
        step();
        chk("busy_refused_ready", 32'(cmd_ready_o), 32'd0);
        cmd_valid_i = 1'b0;
        chk("set_mode_pre_sof", 32'(bus.mode), 32'd0);
        sof_after(9);
        chk("set_mode_sof1", 32'(bus.mode), 32'd2);
        chk("set_rsp_sof1",  32'(rsp_valid_o), 32'd0);
        step();
        chk("set_rsp_sof2",  32'(rsp_valid_o), 32'd1);
        chk("set_err_sof2",  32'(rsp_err_o), 32'd0);
        step();
        chk("set_rsp_pulse", 32'(rsp_valid_o), 32'd0);
        chk("set_ready_back", 32'(cmd_ready_o), 32'd1);
        chk("set_mode_final", 32'(bus.mode), 32'd2);

        // WRITE_COEF sel=0 data=0x00CE6 with SOF on the acceptance cycle
        sof_i = 1'b1;
        send_cmd(2'd1, 2'd0, 20'h00CE6);
        sof_i = 1'b0;
        chk("wr_sof_ignored", 32'(state_o), 32'(ST_WAIT_SOF));
        chk("wr_coef_held", 32'(bus.man_coef), 32'd0);
        sof_after(5);
        chk("wr_lock",     32'(bus.man_lock), 32'd1);
        chk("wr_man_sel",  32'(bus.man_sel),  32'd0);
        chk("wr_man_coef", 32'(bus.man_coef), 32'h00CE6);
        chk("wr_rsp_early", 32'(rsp_valid_o), 32'd0);
        step();
        chk("wr_lock_off", 32'(bus.man_lock), 32'd0);
        chk("wr_rsp",      32'(rsp_valid_o),  32'd1);
        chk("wr_err",      32'(rsp_err_o),    32'd0);
        step();
        chk("wr_lock_count", 32'(lock_cnt),  32'd1);
        chk("wr_lock_coef",  32'(lock_coef), 32'h00CE6);

        // READ_COEF sel=2: data appears READ_LAT+1 cycles after man_sel moves
        send_cmd(2'd2, 2'd2, '0);
        chk("rd_man_sel", 32'(bus.man_sel), 32'd2);
        chk("rd_rsp_a1", 32'(rsp_valid_o), 32'd0);
        step();
        chk("rd_rsp_a2", 32'(rsp_valid_o), 32'd0);
        step();
        chk("rd_rsp_a3", 32'(rsp_valid_o), 32'd0);
        step();
        chk("rd_rsp",  32'(rsp_valid_o), 32'd1);
        chk("rd_err",  32'(rsp_err_o),   32'd0);
        chk("rd_data", 32'(rsp_data_o),  32'h0059F);
        step();
        chk("rd_rsp_pulse", 32'(rsp_valid_o), 32'd0);
        chk("rd_data_hold", 32'(rsp_data_o),  32'h0059F);

        // Bad channel select on WRITE and READ
        send_cmd(2'd1, 2'd3, 20'h11111);
        chk("badw_rsp",   32'(rsp_valid_o), 32'd1);
        chk("badw_err",   32'(rsp_err_o),   32'd1);
        chk("badw_sel",   32'(bus.man_sel), 32'd2);
        chk("badw_ready", 32'(cmd_ready_o), 32'd1);
        step();
        chk("badw_pulse", 32'(rsp_valid_o), 32'd0);
        chk("badw_nolock", 32'(lock_cnt), 32'd1);
        send_cmd(2'd2, 2'd3, '0);
        chk("badr_err",  32'(rsp_err_o),  32'd1);
        chk("badr_data", 32'(rsp_data_o), 32'h0059F);
        step();

        // CALIBRATE, SOF every 100 cycles
        send_cmd(2'd3, 2'd0, '0);
        sof_after(100);
        chk("cal_mode_sof1", 32'(bus.mode), 32'd3);
        chk("cal_state_sof1", 32'(state_o), 32'(ST_CAL_CNT));
        sof_after(100);
        chk("cal_stb_sof2", 32'(bus.cal_stb), 32'd0);
        chk("cal_count_sof2", 32'(stb_cnt), 32'd0);
        sof_after(100);
        chk("cal_stb_sof3", 32'(bus.cal_stb), 32'd1);
        chk("cal_rsp_sof3", 32'(rsp_valid_o), 32'd0);
        step();
        chk("cal_stb_off", 32'(bus.cal_stb), 32'd0);
        chk("cal_rsp",     32'(rsp_valid_o), 32'd1);
        chk("cal_err",     32'(rsp_err_o),   32'd0);
        chk("cal_mode_kept", 32'(bus.mode), 32'd3);
        step();
        chk("cal_stb_count", 32'(stb_cnt), 32'd1);
        chk("no_overlap", 32'(overlap_cnt), 32'd0);

        // Reset in the middle of calibration
        send_cmd(2'd3, 2'd0, '0);
        sof_after(20);
        chk("rcal_state", 32'(state_o), 32'(ST_CAL_CNT));
        do_reset();
        chk("rcal_mode",  32'(bus.mode),    32'd0);
        chk("rcal_state_idle", 32'(state_o), 32'(ST_IDLE));
        chk("rcal_rsp",   32'(rsp_valid_o), 32'd0);
        chk("rcal_ready", 32'(cmd_ready_o), 32'd1);
        chk("rcal_sel",   32'(bus.man_sel), 32'd0);
        chk("rcal_data",  32'(rsp_data_o),  32'd0);

`ifdef WB_SEQ_TIMEOUT_EN
        // Watchdog on SET_MODE: no SOF arrives
        send_cmd(2'd0, 2'd1, '0);
        k = 0;
        while (k < 100 && !rsp_valid_o) begin
            step();
            k++;
        end
        chk("to_set_cycles", 32'(k), 32'd64);
        chk("to_set_err",    32'(rsp_err_o), 32'd1);
        chk("to_set_mode",   32'(bus.mode),  32'd0);
        step();
        // Watchdog in CAL_CNT restores the previous mode
        send_cmd(2'd3, 2'd0, '0);
        sof_after(10);
        chk("to_cal_mode3", 32'(bus.mode), 32'd3);
        k = 0;
        while (k < 100 && !rsp_valid_o) begin
            step();
            k++;
        end
        chk("to_cal_cycles", 32'(k), 32'd64);
        chk("to_cal_err",    32'(rsp_err_o), 32'd1);
        chk("to_cal_mode",   32'(bus.mode),  32'd0);
        step();
`else
        k = 0;
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
